lenet_layer_seq: RTL and testbench
==================================

// Module: lenet_layer_seq
// PURPOSE
//  Generic layer sequencer for the LeNet accelerator. Replaces fixed pairwise
//  start/done wiring between engines (conv_start/conv_done/fc_done/mem_sel).
//  Runs NUM_LAYERS engines in order for a batch of images.
//  Supports per-layer bypass and toggles the ping-pong feature-map select once per image.
// PARAMETERS
//  NUM_LAYERS  4     number of engines sequenced (index 0 runs first)
//  LAYER_W     2     width of cur_layer, >= clog2(NUM_LAYERS)
//  BATCH_W     8     width of batch_len / img_cnt
//  TIMEOUT_CYC 65535 watchdog limit in cycles per layer (only with LAYER_SEQ_TIMEOUT_EN)
// PORTS
//  clk          in   1           clock, rising edge
//  rst          in   1           async reset, active-high
//  start        in   1           batch start request, sampled in IDLE only
//  abort        in   1           sync abort, any state
//  batch_len    in   BATCH_W     images per batch, captured on accepted start
//  layer_bypass in   NUM_LAYERS  1 = skip layer, captured on accepted start
//  layer_done   in   NUM_LAYERS  per-engine done pulses
//  layer_start  out  NUM_LAYERS  one-hot start pulse to engines
//  cur_layer    out  LAYER_W     index of active/last launched layer
//  img_cnt      out  BATCH_W     images completed in current batch
//  mem_sel      out  1           ping-pong buffer select, toggles per image
//  busy         out  1           high in every state except IDLE
//  batch_done   out  1           1-cycle pulse at batch completion
//  err          out  1           sticky watchdog flag, cleared by accepted start
// BEHAVIOUR
//  Reset (async): state=IDLE; all outputs 0 (layer_start, cur_layer, img_cnt, mem_sel, busy, batch_done, err).
//  All outputs registered / Moore. FSM states: IDLE, LAUNCH, WAIT, NEXT, DONE.
//  IDLE: on start, capture batch_len and layer_bypass, clear img_cnt and err.
//   If batch_len==0 or bypass is all ones -> DONE. No layer_start.
//   Otherwise cur_layer = lowest non-bypassed index -> LAUNCH.
//  LAUNCH: layer_start[cur_layer]=1 for exactly this cycle -> WAIT.
//  WAIT: only layer_done[cur_layer] is sampled -> NEXT.
//   layer_done is ignored: in LAUNCH, in any state but WAIT, and on all other bits.
//  NEXT: if a higher non-bypassed layer exists, cur_layer = it -> LAUNCH.
//   Else image complete: img_cnt+1, mem_sel toggles.
//    If the new img_cnt == batch_len -> DONE.
//    Else cur_layer = first non-bypassed -> LAUNCH.
//  DONE: batch_done=1 for one cycle -> IDLE. img_cnt, mem_sel, cur_layer hold.
//  Latency: start edge -> layer_start 1 cycle later.
//   layer_done edge -> next layer_start 2 cycles later (WAIT->NEXT->LAUNCH).
//  start while busy: ignored, no queuing. start and abort together in IDLE: abort wins.
//  abort: next edge -> IDLE. No batch_done. mem_sel and img_cnt hold.
//   An in-flight layer_start pulse still completes this cycle.
//  mem_sel persists across batches and is never reset by start.
//  img_cnt cannot wrap: batch_len <= 2^BATCH_W-1.
//  Reset mid-batch: immediate return to reset values.
//   Engines must be reset by the same rst.
// CONFIGURATION
//  LAYER_SEQ_TIMEOUT_EN defined:
//   In WAIT, a counter increments each cycle; it is cleared on entering WAIT.
//   When it reaches TIMEOUT_CYC with no layer_done: err=1 (sticky), go to IDLE.
//   In that case there is no batch_done and img_cnt holds.
//  LAYER_SEQ_TIMEOUT_EN undefined:
//   No counter logic; err tied to 0; WAIT persists indefinitely.
// TESTING
//  1 NUM_LAYERS=4, batch_len=2, bypass=0, each done 5 cycles after its start:
//    -> starts in order 0,1,2,3,0,1,2,3; mem_sel 0->1->0; img_cnt 2; one batch_done.
//  2 bypass=4'b0101, batch_len=1 -> only layer_start[1] and [3]; cur_layer ends 3; mem_sel toggles once.
//  3 batch_len=0, or bypass=4'b1111 -> no layer_start; batch_done 2 cycles after start; busy high for 1 cycle.
//  4 In WAIT on layer 1: layer_done=4'b0001, then a second start pulse -> both ignored; layer_done[1] advances.
//  5 abort during WAIT of image 1 (of 3) -> IDLE next cycle; no batch_done; img_cnt=1 holds;
//    a new start restarts at img_cnt=0.
//  6 With LAYER_SEQ_TIMEOUT_EN, TIMEOUT_CYC=16, layer 2 never done:
//    -> err=1 exactly 16 cycles after WAIT entry; IDLE; err clears on the next start.

Source files
------------

// File: rtl/lenet_layer_seq.sv
// -----------------------------------------------------------------------------
// lenet_layer_seq
// Generic layer sequencer for the LeNet accelerator. It launches NUM_LAYERS
// engines in ascending index order for every image of a batch, skips the layers
// that are bypassed, and toggles the ping-pong feature-map select after each
// image.
//
// Optional feature: define LAYER_SEQ_TIMEOUT_EN to add a per-layer watchdog.
// If an engine has not signalled done within TIMEOUT_CYC cycles, the watchdog
// sets a sticky err flag and sends the sequencer back to IDLE. Without the
// macro, err is tied low and a layer may wait for as long as it needs.
// -----------------------------------------------------------------------------
module lenet_layer_seq #(
  parameter int NUM_LAYERS  = 4,
  parameter int LAYER_W     = 2,
  parameter int BATCH_W     = 8
`ifdef LAYER_SEQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 65535
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [BATCH_W-1:0]    batch_len,
  input  logic [NUM_LAYERS-1:0] layer_bypass,
  input  logic [NUM_LAYERS-1:0] layer_done,
  output logic [NUM_LAYERS-1:0] layer_start,
  output logic [LAYER_W-1:0]    cur_layer,
  output logic [BATCH_W-1:0]    img_cnt,
  output logic                  mem_sel,
  output logic                  busy,
  output logic                  batch_done,
  output logic                  err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_NEXT   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [NUM_LAYERS-1:0] ONE_HOT0 = NUM_LAYERS'(1'b1);

  // Finds the lowest non-bypassed layer whose index is >= from_idx.
  // Result is {found, index}. The loop runs downwards so that the lowest match wins.
  function automatic logic [LAYER_W:0] find_layer(input logic [NUM_LAYERS-1:0] byp,
                                                  input int from_idx);
    logic [LAYER_W:0] res;
    res = {1'b0, {LAYER_W{1'b0}}};
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if ((i >= from_idx) && !byp[i]) begin
        res = {1'b1, LAYER_W'(i)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  state_t                state_q, state_d;
  logic [NUM_LAYERS-1:0] layer_start_q, layer_start_d;
  logic [LAYER_W-1:0]    cur_layer_q, cur_layer_d;
  logic [BATCH_W-1:0]    img_cnt_q, img_cnt_d;
  logic                  mem_sel_q, mem_sel_d;
  logic                  busy_q, busy_d;
  logic                  batch_done_q, batch_done_d;
  logic [BATCH_W-1:0]    len_q, len_d;
  logic [NUM_LAYERS-1:0] byp_q, byp_d;

  logic [LAYER_W:0]      new_first_s;  // first active layer of the incoming request
  logic [LAYER_W:0]      first_s;      // first active layer of the captured batch
  logic [LAYER_W:0]      next_s;       // next active layer above cur_layer
  logic [BATCH_W-1:0]    img_inc_s;

`ifdef LAYER_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYC - 1);
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            err_q, err_d;
`endif

  // Next-state and next-output computation. Abort has priority over everything else.
  always_comb begin
    state_d      = state_q;
    cur_layer_d  = cur_layer_q;
    img_cnt_d    = img_cnt_q;
    mem_sel_d    = mem_sel_q;
    len_d        = len_q;
    byp_d        = byp_q;
`ifdef LAYER_SEQ_TIMEOUT_EN
    wd_cnt_d     = wd_cnt_q;
    err_d        = err_q;
`endif
    new_first_s  = find_layer(layer_bypass, 32'sd0);
    first_s      = find_layer(byp_q, 32'sd0);
    next_s       = find_layer(byp_q, int'(cur_layer_q) + 32'sd1);
    img_inc_s    = img_cnt_q + BATCH_W'(1'b1);

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            len_d     = batch_len;
            byp_d     = layer_bypass;
            img_cnt_d = {BATCH_W{1'b0}};
`ifdef LAYER_SEQ_TIMEOUT_EN
            err_d     = 1'b0;
`endif
            if ((batch_len == {BATCH_W{1'b0}}) || !new_first_s[LAYER_W]) begin
              state_d = S_DONE;
            end else begin
              cur_layer_d = new_first_s[LAYER_W-1:0];
              state_d     = S_LAUNCH;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_LAUNCH: begin
`ifdef LAYER_SEQ_TIMEOUT_EN
          wd_cnt_d = {WD_W{1'b0}};
`endif
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (layer_done[cur_layer_q]) begin
            state_d = S_NEXT;
          end
`ifdef LAYER_SEQ_TIMEOUT_EN
          else if (wd_cnt_q == WD_LIMIT) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            wd_cnt_d = wd_cnt_q + WD_W'(1'b1);
          end
`else
          else begin
            state_d = S_WAIT;
          end
`endif
        end
        S_NEXT: begin
          if (next_s[LAYER_W]) begin
            cur_layer_d = next_s[LAYER_W-1:0];
            state_d     = S_LAUNCH;
          end else begin
            img_cnt_d = img_inc_s;
            mem_sel_d = ~mem_sel_q;
            if (img_inc_s == len_q) begin
              state_d = S_DONE;
            end else begin
              cur_layer_d = first_s[LAYER_W-1:0];
              state_d     = S_LAUNCH;
            end
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    layer_start_d = (state_d == S_LAUNCH) ? (ONE_HOT0 << cur_layer_d) : {NUM_LAYERS{1'b0}};
    busy_d        = (state_d != S_IDLE);
    batch_done_d  = (state_q == S_DONE) && !abort;
  end

  // State and registered Moore outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      layer_start_q <= {NUM_LAYERS{1'b0}};
      cur_layer_q   <= {LAYER_W{1'b0}};
      img_cnt_q     <= {BATCH_W{1'b0}};
      mem_sel_q     <= 1'b0;
      busy_q        <= 1'b0;
      batch_done_q  <= 1'b0;
      len_q         <= {BATCH_W{1'b0}};
      byp_q         <= {NUM_LAYERS{1'b0}};
    end else begin
      state_q       <= state_d;
      layer_start_q <= layer_start_d;
      cur_layer_q   <= cur_layer_d;
      img_cnt_q     <= img_cnt_d;
      mem_sel_q     <= mem_sel_d;
      busy_q        <= busy_d;
      batch_done_q  <= batch_done_d;
      len_q         <= len_d;
      byp_q         <= byp_d;
    end
  end

`ifdef LAYER_SEQ_TIMEOUT_EN
  // Watchdog counter and its sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_q <= {WD_W{1'b0}};
      err_q    <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      err_q    <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign layer_start = layer_start_q;
  assign cur_layer   = cur_layer_q;
  assign img_cnt     = img_cnt_q;
  assign mem_sel     = mem_sel_q;
  assign busy        = busy_q;
  assign batch_done  = batch_done_q;

endmodule

// File: tb/tb_lenet_layer_seq.sv
// -----------------------------------------------------------------------------
// Scoreboard testbench for lenet_layer_seq.
// The reference model expands each batch request into the expected list of
// layer launches and one expected batch completion. A monitor compares these
// against the DUT whenever the DUT pulses layer_start or batch_done. An engine
// responder answers each launch after a random delay. It also drives done
// pulses that the DUT must ignore, and start pulses while the sequencer is busy.
// -----------------------------------------------------------------------------
module tb_lenet_layer_seq;
  localparam int NL = 4;

  typedef struct {
    int layer;
    int img;
    int mem;
    bit from_done;
  } start_exp_t;

  typedef struct {
    int img;
    int mem;
    int cur;
  } done_exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_m = 1'b0;
  logic       spur_start = 1'b0;
  logic       abort_m = 1'b0;
  logic [7:0] len_m = 8'd0;
  logic [3:0] byp_m = 4'd0;
  logic [3:0] eng_done = 4'd0;
  logic [3:0] spur_done = 4'd0;

  logic [3:0] layer_start;
  logic [1:0] cur_layer;
  logic [7:0] img_cnt;
  logic       mem_sel, busy, batch_done, err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int last_done_cyc = 0;
  int last_launch_cyc = 0;
  int done_seen = 0;
  int exp_mem = 0;
  int exp_cur = 0;
  int hang_layer = -1;
  bit suppress = 1'b0;

  start_exp_t sq[$];
  done_exp_t  dq[$];

  lenet_layer_seq #(
    .NUM_LAYERS(4),
    .LAYER_W(2),
    .BATCH_W(8)
`ifdef LAYER_SEQ_TIMEOUT_EN
    ,
    .TIMEOUT_CYC(16)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start_m | spur_start),
    .abort(abort_m),
    .batch_len(len_m),
    .layer_bypass(byp_m),
    .layer_done(eng_done | spur_done),
    .layer_start(layer_start),
    .cur_layer(cur_layer),
    .img_cnt(img_cnt),
    .mem_sel(mem_sel),
    .busy(busy),
    .batch_done(batch_done),
    .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  // Monitor: pop and compare whenever the DUT presents a launch or a completion.
  always @(negedge clk) begin
    start_exp_t se;
    done_exp_t  de;
    logic [3:0] onehot;
    int         ref_c;
    if (!rst) begin
      if (layer_start != 4'b0000) begin
        last_launch_cyc = cyc;
        if (sq.size() == 0) begin
          check("unexpected_layer_start", int'(layer_start), 0);
        end else begin
          se = sq.pop_front();
          onehot = 4'b0001 << se.layer;
          check("layer_start", int'(layer_start), int'(onehot));
          check("cur_layer_at_start", int'(cur_layer), se.layer);
          check("img_cnt_at_start", int'(img_cnt), se.img);
          check("mem_sel_at_start", int'(mem_sel), se.mem);
          ref_c = se.from_done ? last_done_cyc : start_cyc;
          check("start_latency", cyc - ref_c, se.from_done ? 2 : 1);
        end
      end
      if (batch_done) begin
        done_seen++;
        if (dq.size() == 0) begin
          check("unexpected_batch_done", int'(batch_done), 0);
        end else begin
          de = dq.pop_front();
          check("done_img_cnt", int'(img_cnt), de.img);
          check("done_mem_sel", int'(mem_sel), de.mem);
          check("done_cur_layer", int'(cur_layer), de.cur);
          check("done_busy", int'(busy), 0);
        end
      end
    end
  end

  // Engine responder: answers each launch with a done pulse in WAIT, and
  // drives the pulses the sequencer must ignore.
  initial begin
    int idx, d, wrong;
    logic [3:0] one;
    forever begin
      @(negedge clk);
      if (!rst && layer_start != 4'b0000) begin
        idx = 0;
        for (int i = 0; i < NL; i++) if (layer_start[i]) idx = i;
        d = $urandom_range(2, 6);
        one = 4'b0001;
        if (!suppress && ($urandom % 2 == 0)) spur_done = one << idx;  // LAUNCH: must be ignored
        @(negedge clk);
        spur_done = 4'b0000;
        if (!suppress) begin
          wrong = (idx + 1 + $urandom_range(0, NL - 2)) % NL;
          spur_done  = ($urandom % 2 == 0) ? (one << wrong) : 4'b0000;
          spur_start = ($urandom % 2 == 0);
        end
        @(negedge clk);
        spur_done  = 4'b0000;
        spur_start = 1'b0;
        repeat (d - 2) @(negedge clk);
        if (!suppress && !rst && idx != hang_layer) begin
          eng_done = one << idx;
          last_done_cyc = cyc;
          @(negedge clk);
          eng_done = 4'b0000;
        end
      end
    end
  end

  task automatic wait_idle();
    int k;
    for (k = 0; k < 500 && (busy || batch_done); k++) @(negedge clk);
    if (busy || batch_done) check("wait_idle_timeout", int'(busy), 0);
  endtask

  // Reference model: a batch is every non-bypassed layer, ascending, repeated per image.
  task automatic model_batch(input int len, input logic [3:0] byp, output bit empty);
    int n_act, last;
    bit first;
    n_act = 0;
    last  = 0;
    for (int i = 0; i < NL; i++) if (!byp[i]) begin n_act++; last = i; end
    empty = (len == 0) || (n_act == 0);
    if (empty) begin
      dq.push_back('{0, exp_mem, exp_cur});
    end else begin
      first = 1'b1;
      for (int im = 0; im < len; im++) begin
        for (int l = 0; l < NL; l++) begin
          if (!byp[l]) begin
            sq.push_back('{l, im, exp_mem, !first});
            first = 1'b0;
          end
        end
        exp_mem ^= 1;
      end
      exp_cur = last;
      dq.push_back('{len, exp_mem, last});
    end
  endtask

  task automatic issue_start(input int len, input logic [3:0] byp);
    @(negedge clk);
    start_m   = 1'b1;
    len_m     = 8'(len);
    byp_m     = byp;
    start_cyc = cyc;
    @(negedge clk);
    start_m = 1'b0;
  endtask

  task automatic run_batch(input int len, input logic [3:0] byp);
    bit empty;
    int target, k;
    wait_idle();
    model_batch(len, byp, empty);
    target = done_seen + 1;
    issue_start(len, byp);
    check("busy_after_start", int'(busy), 1);
    check("err_cleared_on_start", int'(err), 0);
    if (empty) begin
      check("empty_no_layer_start", int'(layer_start), 0);
      @(negedge clk);
      check("empty_busy_one_cycle", int'(busy), 0);
      check("empty_batch_done_2cyc", int'(batch_done), 1);
    end
    for (k = 0; k < 3000 && done_seen != target; k++) @(negedge clk);
    check("batch_completed", done_seen, target);
  endtask

  initial begin
    int k;
    bit found;
    #500000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int k;
    bit found;
    repeat (3) @(negedge clk);
    check("rst_layer_start", int'(layer_start), 0);
    check("rst_cur_layer", int'(cur_layer), 0);
    check("rst_img_cnt", int'(img_cnt), 0);
    check("rst_mem_sel", int'(mem_sel), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_batch_done", int'(batch_done), 0);
    check("rst_err", int'(err), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_batch(2, 4'b0000);
    run_batch(1, 4'b0101);
    run_batch(0, 4'b0000);
    run_batch(3, 4'b1111);

    // Abort during WAIT of image 1 of 3.
    wait_idle();
    for (int l = 0; l < NL; l++) sq.push_back('{l, 0, exp_mem, l != 0});
    exp_mem ^= 1;
    sq.push_back('{0, 1, exp_mem, 1'b1});
    exp_cur = 0;
    issue_start(3, 4'b0000);
    found = 1'b0;
    for (k = 0; k < 500 && !found; k++) begin
      if (layer_start != 4'b0000 && img_cnt == 8'd1) found = 1'b1;
      else @(negedge clk);
    end
    suppress = 1'b1;
    check("abort_reached_image1", int'(found), 1);
    @(negedge clk);
    abort_m = 1'b1;
    @(negedge clk);
    abort_m = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_img_cnt_hold", int'(img_cnt), 1);
    check("abort_mem_sel_hold", int'(mem_sel), exp_mem);
    repeat (12) @(negedge clk);
    check("abort_launches_drained", sq.size(), 0);
    suppress = 1'b0;
    run_batch(2, 4'b0000);

    // start and abort together in IDLE: abort wins.
    wait_idle();
    @(negedge clk);
    start_m = 1'b1;
    abort_m = 1'b1;
    len_m   = 8'd2;
    byp_m   = 4'b0000;
    @(negedge clk);
    start_m = 1'b0;
    abort_m = 1'b0;
    check("start_abort_busy", int'(busy), 0);
    check("start_abort_no_launch", int'(layer_start), 0);
    @(negedge clk);
    check("start_abort_still_idle", int'(busy), 0);

    // Randomized batches.
    for (int b = 0; b < 10; b++) begin
      run_batch($urandom_range(0, 4), 4'($urandom_range(0, 15)));
    end

    // Reset in the middle of a batch.
    wait_idle();
    suppress = 1'b1;
    sq.push_back('{0, 0, exp_mem, 1'b0});
    issue_start(4, 4'b0000);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_layer_start", int'(layer_start), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_img_cnt", int'(img_cnt), 0);
    check("midrst_mem_sel", int'(mem_sel), 0);
    check("midrst_cur_layer", int'(cur_layer), 0);
    @(negedge clk);
    rst = 1'b0;
    sq.delete();
    dq.delete();
    exp_mem = 0;
    exp_cur = 0;
    repeat (10) @(negedge clk);
    suppress = 1'b0;
    run_batch(1, 4'b0110);

`ifdef LAYER_SEQ_TIMEOUT_EN
    // Layer 2 never reports done: the watchdog must fire 16 cycles after WAIT entry.
    wait_idle();
    hang_layer = 2;
    for (int l = 0; l < 3; l++) sq.push_back('{l, 0, exp_mem, l != 0});
    exp_cur = 2;
    issue_start(1, 4'b0000);
    for (k = 0; k < 300 && !err; k++) @(negedge clk);
    check("timeout_err_set", int'(err), 1);
    check("timeout_latency", cyc - last_launch_cyc, 17);
    check("timeout_busy", int'(busy), 0);
    check("timeout_img_cnt", int'(img_cnt), 0);
    check("timeout_cur_layer", int'(cur_layer), 2);
    repeat (8) @(negedge clk);
    check("timeout_err_sticky", int'(err), 1);
    hang_layer = -1;
    run_batch(1, 4'b0000);
`endif

    wait_idle();
    repeat (4) @(negedge clk);
    check("final_launch_queue_empty", sq.size(), 0);
    check("final_done_queue_empty", dq.size(), 0);
    check("final_err", int'(err), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
